decoder_pipe: RTL and testbench

Parametrised, pipelined successor of the 4-to-16 one-hot address decoder. Accepts W-bit addresses over a valid/ready handshake, decodes each to an N-bit one-hot or thermometer code, and buffers results in a 2-entry output FIFO so both sides can stall independently. Sits between address-generation logic and downstream select/enable consumers that apply backpressure.

---
 rtl/decoder_pipe.sv | 111 +++++++++++
 tb/tb_decoder_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_pipe.sv
// Pipelined W-bit to N-bit one-hot/thermometer decoder with a 2-entry output FIFO.
// Optional macro DECODER_PIPE_OOR_ERR_EN enables the out-of-range tag on err.
module decoder_pipe #(
  parameter int W = 4,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         err
);

  localparam int           WP    = W + 1;
  localparam logic [W:0]   N_LIM = WP'(N);

  // Raw decode before range gating; thermometer sets every bit at or below the address.
  function automatic logic [N-1:0] decode_raw(input logic [W-1:0] a, input logic m);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (m) begin
        r[i] = (WP'(i) <= {1'b0, a});
      end else begin
        r[i] = (WP'(i) == {1'b0, a});
      end
    end
    return r;
  endfunction

  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [N-1:0] z_mem_q [2];
  logic [N-1:0] dec_z_s;
  logic         oor_s;
  logic         push_s;
  logic         pop_s;

  // Ready/valid are gated by rst so nothing moves during the reset cycle.
  assign in_ready  = (count_q != 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0) && !rst;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign Z         = out_valid ? z_mem_q[rd_ptr_q] : {N{1'b0}};

  // Decode the offered beat; out-of-range addresses yield an all-zero result.
  always_comb begin
    oor_s   = ({1'b0, A} >= N_LIM);
    dec_z_s = oor_s ? {N{1'b0}} : decode_raw(A, mode);
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + 2'd1;
    end else if (!push_s && pop_s) begin
      count_d = count_q - 2'd1;
    end else begin
      count_d = count_q;
    end
    wr_ptr_d = push_s ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop_s ? ~rd_ptr_q : rd_ptr_q;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage; contents are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (push_s) begin
      z_mem_q[wr_ptr_q] <= dec_z_s;
    end
  end

`ifdef DECODER_PIPE_OOR_ERR_EN
  logic [1:0] oor_mem_q;

  // Out-of-range tag travels alongside each payload entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      oor_mem_q <= 2'b00;
    end else if (push_s) begin
      oor_mem_q[wr_ptr_q] <= oor_s;
    end
  end

  assign err = out_valid ? oor_mem_q[rd_ptr_q] : 1'b0;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Scoreboard bench for decoder_pipe: a default W=4/N=16 instance and a W=4/N=10 instance.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid0, in_ready0, mode0, out_valid0, out_ready0, err0;
  logic [3:0]  A0;
  logic [15:0] Z0;
  logic        in_valid1, in_ready1, mode1, out_valid1, out_ready1, err1;
  logic [3:0]  A1;
  logic [9:0]  Z1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q0z[$];
  logic        q0e[$];
  logic [15:0] q1z[$];
  logic        q1e[$];

  always #5 clk = ~clk;

  decoder_pipe dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .A(A0), .mode(mode0),
    .out_valid(out_valid0), .out_ready(out_ready0), .Z(Z0), .err(err0)
  );

  decoder_pipe #(.W(4), .N(10)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .A(A1), .mode(mode1),
    .out_valid(out_valid1), .out_ready(out_ready1), .Z(Z1), .err(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_z(input int a, input logic m, input int n);
    logic [31:0] one;
    one = 32'd1;
    if (a >= n) return 16'h0000;
    if (m) return 16'((one << (a + 1)) - 32'd1);
    return 16'(one << a);
  endfunction

  function automatic logic model_err(input int a, input int n);
`ifdef DECODER_PIPE_OOR_ERR_EN
    return (a >= n);
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard for instance 0: compare head, pop on handshake, push on accept.
  always @(negedge clk) begin
    if (rst) begin
      q0z.delete(); q0e.delete();
      check_eq("rst_rdy0", 32'(in_ready0), 32'd0);
      check_eq("rst_vld0", 32'(out_valid0), 32'd0);
      check_eq("rst_z0", 32'(Z0), 32'd0);
    end else begin
      check_eq("rdy0", 32'(in_ready0), 32'(q0z.size() < 2));
      check_eq("vld0", 32'(out_valid0), 32'(q0z.size() > 0));
      if (out_valid0 && q0z.size() > 0) begin
        check_eq("z0", 32'(Z0), 32'(q0z[0]));
        check_eq("err0", 32'(err0), 32'(q0e[0]));
        if (out_ready0) begin
          void'(q0z.pop_front()); void'(q0e.pop_front());
        end
      end else begin
        check_eq("idle_z0", 32'(Z0), 32'd0);
      end
      if (in_valid0 && in_ready0) begin
        q0z.push_back(model_z(int'(A0), mode0, 16));
        q0e.push_back(model_err(int'(A0), 16));
      end
    end
  end

  // Scoreboard for instance 1 (N=10, has out-of-range addresses).
  always @(negedge clk) begin
    if (rst) begin
      q1z.delete(); q1e.delete();
      check_eq("rst_vld1", 32'(out_valid1), 32'd0);
    end else begin
      check_eq("rdy1", 32'(in_ready1), 32'(q1z.size() < 2));
      check_eq("vld1", 32'(out_valid1), 32'(q1z.size() > 0));
      if (out_valid1 && q1z.size() > 0) begin
        check_eq("z1", 32'(Z1), 32'(q1z[0]));
        check_eq("err1", 32'(err1), 32'(q1e[0]));
        if (out_ready1) begin
          void'(q1z.pop_front()); void'(q1e.pop_front());
        end
      end else begin
        check_eq("idle_err1", 32'(err1), 32'd0);
      end
      if (in_valid1 && in_ready1) begin
        q1z.push_back(model_z(int'(A1), mode1, 10));
        q1e.push_back(model_err(int'(A1), 10));
      end
    end
  end

  // Offer one beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input int sel, input int a, input logic m);
    int n;
    n = 0;
    if (sel == 0) begin
      in_valid0 = 1'b1; A0 = 4'(a); mode0 = m;
    end else begin
      in_valid1 = 1'b1; A1 = 4'(a); mode1 = m;
    end
    @(negedge clk);
    while (((sel == 0) ? !in_ready0 : !in_ready1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_wait", 32'(n < 100), 32'd1);
    @(posedge clk);
    #1;
    if (sel == 0) in_valid0 = 1'b0;
    else in_valid1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid0 = 1'b0; A0 = 4'd0; mode0 = 1'b0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; A1 = 4'd0; mode1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_rdy", 32'(in_ready0), 32'd1);
    check_eq("post_rst_vld", 32'(out_valid0), 32'd0);

    // Basic one-hot and thermometer, one-cycle latency
    send(0, 2, 1'b0);
    check_eq("basic_vld", 32'(out_valid0), 32'd1);
    check_eq("basic_z", 32'(Z0), 32'h0004);
    send(0, 5, 1'b1);
    check_eq("therm5", 32'(Z0), 32'h003F);
    send(0, 15, 1'b1);
    check_eq("therm15", 32'(Z0), 32'hFFFF);
    send(0, 0, 1'b1);
    check_eq("therm0", 32'(Z0), 32'h0001);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: two accepted, third held until first pop
    out_ready0 = 1'b0;
    send(0, 1, 1'b0);
    send(0, 3, 1'b0);
    in_valid0 = 1'b1; A0 = 4'd7; mode0 = 1'b0;
    @(negedge clk);
    check_eq("bp_full", 32'(in_ready0), 32'd0);
    check_eq("bp_head1", 32'(Z0), 32'h0002);
    @(posedge clk);
    #1 out_ready0 = 1'b1;
    @(negedge clk);
    check_eq("bp_still_full", 32'(in_ready0), 32'd0);
    @(negedge clk);
    check_eq("bp_freed", 32'(in_ready0), 32'd1);
    check_eq("bp_head2", 32'(Z0), 32'h0008);
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    @(negedge clk);
    check_eq("bp_head3", 32'(Z0), 32'h0080);
    repeat (2) @(posedge clk);
    #1;

    // Continuous stream with simultaneous push/pop at count 1
    for (int a = 0; a < 16; a++) begin
      send(0, a, 1'b0);
      check_eq("stream_vld", 32'(out_valid0), 32'd1);
      check_eq("stream_rdy", 32'(in_ready0), 32'd1);
      check_eq("stream_z", 32'(Z0), 32'(model_z(a, 1'b0, 16)));
    end
    repeat (2) @(posedge clk);
    #1;

    // Out-of-range on the N=10 instance
    send(1, 12, 1'b0);
    check_eq("oor_z", 32'(Z1), 32'h000);
    check_eq("oor_err", 32'(err1), 32'(model_err(12, 10)));
    send(1, 9, 1'b0);
    check_eq("inr_z", 32'(Z1), 32'h200);
    check_eq("inr_err", 32'(err1), 32'd0);
    send(1, 12, 1'b1);
    check_eq("oor_therm_z", 32'(Z1), 32'h000);
    send(1, 3, 1'b1);
    check_eq("therm3_n10", 32'(Z1), 32'h00F);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-operation discards buffered entries
    out_ready0 = 1'b0;
    send(0, 4, 1'b0);
    send(0, 5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_rdy", 32'(in_ready0), 32'd0);
    check_eq("mid_rst_vld", 32'(out_valid0), 32'd0);
    check_eq("mid_rst_z", 32'(Z0), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("after_rst_rdy", 32'(in_ready0), 32'd1);
    check_eq("after_rst_vld", 32'(out_valid0), 32'd0);
    out_ready0 = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("no_stale_vld", 32'(out_valid0), 32'd0);
    check_eq("drain0", 32'(q0z.size()), 32'd0);
    check_eq("drain1", 32'(q1z.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
